commit_trace: RTL and testbench
===============================

COMMIT_TRACE -- requirements
Module: commit_trace

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, record buffer depth, power of two, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 16, width of the drop counter.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-004 SHALL have IF-stage inputs: if_valid in 1; if_pc in 32; if_inst in 32.
REQ-005 SHALL have EX-stage inputs (IF+2): ex_is_jump in 1; ex_jump_addr in 32.
REQ-006 SHALL have MEM-stage inputs (IF+3): mem_read in 1; mem_write in 1; mem_addr in 32; mem_data_r in 32; mem_data_w in 32; mem_wait in 1, pipeline stall.
REQ-007 SHALL have WB-stage inputs (IF+4): wb_flush in 1; wb_reg_wr in 1; wb_reg_addr in 5; wb_reg_data in 32.
REQ-008 SHALL have record outputs: trc_valid out 1; trc_ready in 1; trc_pc, trc_inst, trc_jump_addr, trc_mem_addr, trc_mem_data, trc_rd_data out 32 each; trc_rd_addr out 5; trc_rd_wr, trc_is_jump, trc_mem_rd, trc_mem_wr out 1 each.
REQ-009 SHALL have status outputs: retire_cnt out 32; drop_cnt out CNT_W; overflow out 1, sticky.

Function
REQ-010 SHALL hold a 5-slot alignment line (slots 0..4 = IF..WB), each slot carrying a valid bit plus fields captured at its stage.
REQ-011 On a clk edge with mem_wait=0, SHALL shift slots 0..3 into 1..4 and load slot 0 from if_valid/if_pc/if_inst.
REQ-012 With mem_wait=0, SHALL capture ex_* into the record entering slot 3, mem_* into the record entering slot 4, and wb_* alongside slot 4 retirement, matching offsets IF+2/+3/+4.
REQ-013 With mem_wait=1, SHALL hold all slots, perform no capture and no retirement; FIFO pop SHALL still proceed.
REQ-014 Retirement SHALL occur on a non-stalled edge when slot 4 is valid; wb_flush=1 at that edge SHALL discard the record (not pushed, not counted).
REQ-015 Record trc_mem_data SHALL be mem_data_w when mem_write=1, else mem_data_r.
REQ-016 Non-flushed retirement SHALL increment retire_cnt (wraps at 2^32) and push one record into the FIFO.
REQ-017 Push when FIFO full and no pop in the same edge SHALL drop the record, increment drop_cnt (saturating at all-ones), set overflow.
REQ-018 Simultaneous push and pop when full SHALL accept both; occupancy unchanged, no drop.
REQ-019 Pop SHALL occur on edges where trc_valid=1 and trc_ready=1; trc_valid SHALL equal FIFO non-empty.
REQ-020 trc_* outputs SHALL present the FIFO head registered; latency from retirement edge to trc_valid=1 SHALL be 1 cycle when empty.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; empty and full SHALL be distinguished by an extra pointer bit.
REQ-022 trc_* fields SHALL stay stable while trc_valid=1 and trc_ready=0.

Reset
REQ-023 rst=1 SHALL asynchronously clear all slot valid bits, FIFO pointers, retire_cnt, drop_cnt, overflow; all outputs SHALL read 0.
REQ-024 Reset mid-operation SHALL discard in-flight and buffered records; no record SHALL emerge for instructions entered before reset release.

Structure
REQ-025 Stage offsets (2,3,4) and record field widths SHALL be constants in defines.vh.
REQ-026 The buffer SHALL be a sub-module trace_fifo (parameterised depth/width, push/pop/full/empty).
REQ-027 Block SHALL be synthesizable; no $display or simulation-only constructs.

Verification
REQ-028 Single ADDI at if_pc=0x100, if_inst=0x00500093, wb_reg_wr=1, addr 1, data 5, trc_ready=1 -> trc_valid pulse 5 cycles after entry, trc_pc=0x100, trc_rd_addr=1, trc_rd_data=5, retire_cnt=1.
REQ-029 SW at pc 0x104, mem_write=1, mem_addr=0x2000, mem_data_w=0xDEADBEEF, mem_wait=1 for 3 cycles at MEM -> record retires 3 cycles late, trc_mem_wr=1, trc_mem_data=0xDEADBEEF.
REQ-030 JAL at pc 0x108, ex_is_jump=1, ex_jump_addr=0x200, next two records wb_flush=1 -> one record with trc_jump_addr=0x200, flushed pair absent, retire_cnt+1 only.
REQ-031 trc_ready=0, 6 consecutive retirements, depth 4 -> 4 records buffered, drop_cnt=2, overflow=1; then trc_ready=1 -> first 4 PCs drained in order.
REQ-032 FIFO full, trc_ready=1 with retirement same edge -> no drop, occupancy stays 4.
REQ-033 rst asserted asynchronously with 3 records buffered and 2 in flight -> trc_valid=0 immediately, counters 0, no stale records after release.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// rtl/commit_trace_pkg.sv - shared types and constants for the commit tracer
package commit_trace_pkg;
`include "defines.vh"

  // A record is captured from a stage input on the edge where it leaves slot <offset>
  localparam int EX_OFF    = `CT_EX_OFF;
  localparam int MEM_OFF   = `CT_MEM_OFF;
  localparam int WB_OFF    = `CT_WB_OFF;
  localparam int NUM_SLOTS = WB_OFF + 1;
  localparam int XLEN      = `CT_XLEN;
  localparam int REG_W     = `CT_REG_W;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            is_jump;
    logic [XLEN-1:0] jump_addr;
    logic            mem_rd;
    logic            mem_wr;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } slot_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  jump_addr;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_data;
    logic [XLEN-1:0]  rd_data;
    logic [REG_W-1:0] rd_addr;
    logic             rd_wr;
    logic             is_jump;
    logic             mem_rd;
    logic             mem_wr;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // Stores report the written value, everything else the loaded value
  function automatic logic [XLEN-1:0] sel_mem_data(input logic wr, input logic [XLEN-1:0] data_w,
                                                   input logic [XLEN-1:0] data_r);
    return wr ? data_w : data_r;
  endfunction
endpackage

// File: rtl/defines.vh
// rtl/defines.vh - stage offsets and record field widths for commit_trace
`ifndef COMMIT_TRACE_DEFINES_VH
`define COMMIT_TRACE_DEFINES_VH
`define CT_EX_OFF  2
`define CT_MEM_OFF 3
`define CT_WB_OFF  4
`define CT_XLEN    32
`define CT_REG_W   5
`endif

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - record buffer with wrap-bit pointers and zeroed head when empty
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on a full buffer frees the slot being written this edge
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer update; the extra top bit separates full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/commit_trace.sv
// rtl/commit_trace.sv - aligns per-stage pipeline signals into one retirement record
module commit_trace
  import commit_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_jump_addr,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_data_r,
  input  logic [31:0]      mem_data_w,
  input  logic             mem_wait,
  input  logic             wb_flush,
  input  logic             wb_reg_wr,
  input  logic [4:0]       wb_reg_addr,
  input  logic [31:0]      wb_reg_data,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [31:0]      trc_pc,
  output logic [31:0]      trc_inst,
  output logic [31:0]      trc_jump_addr,
  output logic [31:0]      trc_mem_addr,
  output logic [31:0]      trc_mem_data,
  output logic [31:0]      trc_rd_data,
  output logic [4:0]       trc_rd_addr,
  output logic             trc_rd_wr,
  output logic             trc_is_jump,
  output logic             trc_mem_rd,
  output logic             trc_mem_wr,
  output logic [31:0]      retire_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);
  slot_t      line     [NUM_SLOTS];
  slot_t      line_nxt [NUM_SLOTS];
  trace_rec_t rec;
  trace_rec_t head;
  logic       retire;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;

  // Next alignment line: shift by one stage and capture each stage's inputs as the record leaves it
  always_comb begin
    line_nxt[0]       = '0;
    line_nxt[0].valid = if_valid;
    line_nxt[0].pc    = if_pc;
    line_nxt[0].inst  = if_inst;
    for (int i = 1; i < NUM_SLOTS; i++) line_nxt[i] = line[i-1];
    line_nxt[EX_OFF+1].is_jump    = ex_is_jump;
    line_nxt[EX_OFF+1].jump_addr  = ex_jump_addr;
    line_nxt[MEM_OFF+1].mem_rd    = mem_read;
    line_nxt[MEM_OFF+1].mem_wr    = mem_write;
    line_nxt[MEM_OFF+1].mem_addr  = mem_addr;
    line_nxt[MEM_OFF+1].mem_data  = sel_mem_data(mem_write, mem_data_w, mem_data_r);
  end

  // Alignment line advances only when the pipeline is not stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) line[i] <= '0;
    end else if (!mem_wait) begin
      line <= line_nxt;
    end
  end

  assign retire = !mem_wait && line[WB_OFF].valid;
  assign push   = retire && !wb_flush;
  assign pop    = trc_valid && trc_ready;
  assign drop   = push && full && !pop;

  // Retiring record: aligned fields from the last slot plus the live WB inputs
  always_comb begin
    rec           = '0;
    rec.pc        = line[WB_OFF].pc;
    rec.inst      = line[WB_OFF].inst;
    rec.is_jump   = line[WB_OFF].is_jump;
    rec.jump_addr = line[WB_OFF].jump_addr;
    rec.mem_rd    = line[WB_OFF].mem_rd;
    rec.mem_wr    = line[WB_OFF].mem_wr;
    rec.mem_addr  = line[WB_OFF].mem_addr;
    rec.mem_data  = line[WB_OFF].mem_data;
    rec.rd_wr     = wb_reg_wr;
    rec.rd_addr   = wb_reg_addr;
    rec.rd_data   = wb_reg_data;
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rec),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign trc_valid     = !empty;
  assign trc_pc        = head.pc;
  assign trc_inst      = head.inst;
  assign trc_jump_addr = head.jump_addr;
  assign trc_mem_addr  = head.mem_addr;
  assign trc_mem_data  = head.mem_data;
  assign trc_rd_data   = head.rd_data;
  assign trc_rd_addr   = head.rd_addr;
  assign trc_rd_wr     = head.rd_wr;
  assign trc_is_jump   = head.is_jump;
  assign trc_mem_rd    = head.mem_rd;
  assign trc_mem_wr    = head.mem_wr;

  // Status counters: retirements wrap, drops saturate, overflow is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) retire_cnt <= retire_cnt + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_commit_trace.sv
// tb/tb_commit_trace.sv - directed self-checking bench for commit_trace
module tb_commit_trace;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        ex_is_jump;
  logic [31:0] ex_jump_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_r;
  logic [31:0] mem_data_w;
  logic        mem_wait;
  logic        wb_flush;
  logic        wb_reg_wr;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;
  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_pc;
  logic [31:0] trc_inst;
  logic [31:0] trc_jump_addr;
  logic [31:0] trc_mem_addr;
  logic [31:0] trc_mem_data;
  logic [31:0] trc_rd_data;
  logic [4:0]  trc_rd_addr;
  logic        trc_rd_wr;
  logic        trc_is_jump;
  logic        trc_mem_rd;
  logic        trc_mem_wr;
  logic [31:0] retire_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  commit_trace #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .ex_is_jump(ex_is_jump), .ex_jump_addr(ex_jump_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_r(mem_data_r), .mem_data_w(mem_data_w), .mem_wait(mem_wait),
    .wb_flush(wb_flush), .wb_reg_wr(wb_reg_wr), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data),
    .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_pc(trc_pc), .trc_inst(trc_inst), .trc_jump_addr(trc_jump_addr),
    .trc_mem_addr(trc_mem_addr), .trc_mem_data(trc_mem_data), .trc_rd_data(trc_rd_data),
    .trc_rd_addr(trc_rd_addr), .trc_rd_wr(trc_rd_wr), .trc_is_jump(trc_is_jump),
    .trc_mem_rd(trc_mem_rd), .trc_mem_wr(trc_mem_wr),
    .retire_cnt(retire_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One rising edge, returning at the following falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_valid = 0; if_pc = 0; if_inst = 0;
    ex_is_jump = 0; ex_jump_addr = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0; mem_data_r = 0; mem_data_w = 0; mem_wait = 0;
    wb_flush = 0; wb_reg_wr = 0; wb_reg_addr = 0; wb_reg_data = 0;
  endtask

  initial begin
    rst = 1; trc_ready = 0;
    clear_inputs();
    step(); step();
    chk("rst_valid", 32'(trc_valid), 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_pc", trc_pc, 0);
    rst = 0;

    // Single ADDI
    if_valid = 1; if_pc = 32'h100; if_inst = 32'h0050_0093; trc_ready = 1;
    step();
    if_valid = 0;
    step(); step(); step(); step();
    chk("addi_early", 32'(trc_valid), 0);
    wb_reg_wr = 1; wb_reg_addr = 5'd1; wb_reg_data = 32'd5;
    step();
    chk("addi_valid", 32'(trc_valid), 1);
    chk("addi_pc", trc_pc, 32'h100);
    chk("addi_inst", trc_inst, 32'h0050_0093);
    chk("addi_rd_addr", 32'(trc_rd_addr), 1);
    chk("addi_rd_data", trc_rd_data, 5);
    chk("addi_rd_wr", 32'(trc_rd_wr), 1);
    chk("addi_retire", retire_cnt, 1);
    wb_reg_wr = 0; wb_reg_addr = 0; wb_reg_data = 0;
    step();
    chk("addi_popped", 32'(trc_valid), 0);

    // SW with a three-cycle MEM stall
    if_valid = 1; if_pc = 32'h104; if_inst = 32'h00A1_2023;
    step();
    if_valid = 0;
    step(); step(); step();
    mem_write = 1; mem_addr = 32'h2000; mem_data_w = 32'hDEAD_BEEF; mem_data_r = 32'h1234_5678; mem_wait = 1;
    step(); step(); step();
    chk("sw_stalled", 32'(trc_valid), 0);
    mem_wait = 0;
    step();
    mem_write = 0; mem_addr = 0; mem_data_w = 0; mem_data_r = 0;
    chk("sw_not_yet", 32'(trc_valid), 0);
    step();
    chk("sw_valid", 32'(trc_valid), 1);
    chk("sw_pc", trc_pc, 32'h104);
    chk("sw_mem_wr", 32'(trc_mem_wr), 1);
    chk("sw_mem_rd", 32'(trc_mem_rd), 0);
    chk("sw_mem_addr", trc_mem_addr, 32'h2000);
    chk("sw_mem_data", trc_mem_data, 32'hDEAD_BEEF);
    chk("sw_rd_wr", 32'(trc_rd_wr), 0);
    chk("sw_retire", retire_cnt, 2);
    step();
    chk("sw_popped", 32'(trc_valid), 0);

    // JAL followed by two flushed instructions
    if_valid = 1; if_pc = 32'h108; if_inst = 32'h2000_00EF;
    step();
    if_pc = 32'h10C; if_inst = 32'h0000_0013;
    step();
    if_pc = 32'h110;
    step();
    if_valid = 0; ex_is_jump = 1; ex_jump_addr = 32'h200;
    step();
    ex_is_jump = 0; ex_jump_addr = 0;
    step();
    step();
    chk("jal_valid", 32'(trc_valid), 1);
    chk("jal_pc", trc_pc, 32'h108);
    chk("jal_is_jump", 32'(trc_is_jump), 1);
    chk("jal_target", trc_jump_addr, 32'h200);
    wb_flush = 1;
    step();
    chk("flush1_absent", 32'(trc_valid), 0);
    step();
    chk("flush2_absent", 32'(trc_valid), 0);
    chk("jal_retire", retire_cnt, 3);
    wb_flush = 0;

    // Six retirements into a depth-4 buffer with the consumer stalled
    trc_ready = 0;
    for (int k = 0; k < 6; k++) begin
      if_valid = 1; if_pc = 32'h300 + 32'(4 * k); if_inst = 32'h13;
      step();
    end
    if_valid = 0;
    step(); step(); step(); step(); step();
    chk("ovf_valid", 32'(trc_valid), 1);
    chk("ovf_head", trc_pc, 32'h300);
    chk("ovf_drop", 32'(drop_cnt), 2);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_retire", retire_cnt, 9);
    step();
    chk("ovf_stable_pc", trc_pc, 32'h300);
    chk("ovf_stable_valid", 32'(trc_valid), 1);

    // Full buffer: pop and retirement on the same edge
    if_valid = 1; if_pc = 32'h400;
    step();
    if_valid = 0;
    step(); step(); step(); step();
    trc_ready = 1;
    step();
    chk("pp_drop", 32'(drop_cnt), 2);
    chk("pp_head", trc_pc, 32'h304);
    chk("pp_retire", retire_cnt, 10);
    step();
    chk("drain_308", trc_pc, 32'h308);
    step();
    chk("drain_30c", trc_pc, 32'h30C);
    step();
    chk("drain_400", trc_pc, 32'h400);
    chk("drain_400_valid", 32'(trc_valid), 1);
    step();
    chk("drain_empty", 32'(trc_valid), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);

    // Asynchronous reset with 3 buffered and 2 in flight
    trc_ready = 0;
    for (int k = 0; k < 5; k++) begin
      if_valid = 1; if_pc = 32'h500 + 32'(4 * k);
      step();
    end
    if_valid = 0;
    step(); step(); step();
    chk("pre_rst_valid", 32'(trc_valid), 1);
    chk("pre_rst_head", trc_pc, 32'h500);
    chk("pre_rst_retire", retire_cnt, 13);
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(trc_valid), 0);
    chk("arst_retire", retire_cnt, 0);
    chk("arst_drop", 32'(drop_cnt), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_pc", trc_pc, 0);
    step();
    rst = 0; trc_ready = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_no_record", 32'(trc_valid), 0);
    end
    chk("post_rst_retire", retire_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
